// File: rtl/instr_prefetch_buffer_if.sv
// Fetch-control, memory-port and instruction-stream signals of the prefetch buffer.
// The master modport belongs to the prefetch buffer; the slave modport is for the core and memory side.
interface instr_prefetch_buffer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_en_i;
  logic                  branch_i;
  logic [ADDR_WIDTH-1:0] branch_addr_i;
  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [DATA_WIDTH-1:0] instr_rdata_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;

  modport master (
    input  fetch_en_i, branch_i, branch_addr_i, mem_rdata_i, instr_ready_i,
    output mem_en_o, mem_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o
  );

  modport slave (
    output fetch_en_i, branch_i, branch_addr_i, mem_rdata_i, instr_ready_i,
    input  mem_en_o, mem_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch from a 1-cycle-latency memory into a small FIFO.
// Request-to-valid latency is 2 cycles; requests stop when FIFO entries plus in-flight reads would exceed DEPTH.
module instr_prefetch_buffer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 16'h8000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instr_prefetch_buffer_if.master  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] faddr;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic                  pend_q;
  logic [2:0]            count;
  logic [1:0]            wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_dat [4];
  logic [ADDR_WIDTH-1:0] fifo_addr [4];

  logic                  branch, pop, push, req;
  logic [2:0]            cnt_eff, occ;
  logic [ADDR_WIDTH-1:0] baddr_al, req_addr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.fetch_en_i)  state_d = RUN;
      RUN:     if (!bus.fetch_en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A branch flushes everything, so the occupancy check sees an empty buffer with nothing in flight.
  assign branch   = bus.branch_i;
  assign baddr_al = bus.branch_addr_i & ~ADDR_WIDTH'(3);
  assign pop      = bus.instr_valid_o & bus.instr_ready_i;
  assign cnt_eff  = branch ? 3'd0 : count;
  assign occ      = cnt_eff + 3'((pend_q & ~branch)) - 3'(pop);
  assign req      = rst_n && (state_d == RUN) && (occ < 3'(DEPTH));
  assign req_addr = branch ? baddr_al : faddr;
  assign push     = pend_q & ~branch;

  assign bus.mem_en_o      = req;
  assign bus.mem_addr_o    = req_addr;
  assign bus.instr_valid_o = (count != 3'd0) && !branch;
  assign bus.instr_rdata_o = fifo_dat[rd_ptr];
  assign bus.instr_addr_o  = fifo_addr[rd_ptr];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      faddr       <= BOOT_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= req;
      pend_addr_q <= req_addr;
      if (req)
        faddr <= req_addr + ADDR_WIDTH'(4);
      else if (branch)
        faddr <= baddr_al;
      if (branch) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count + 3'(push) - 3'(pop);
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr]  <= bus.mem_rdata_i;
      fifo_addr[wr_ptr] <= pend_addr_q;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench: boot, backpressure, branch flush, address wrap, stop, and reset with a full FIFO.
module tb_instr_prefetch_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instr_prefetch_buffer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  instr_prefetch_buffer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(2), .BOOT_ADDR(16'h8000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory returns {~addr, addr} one cycle after the request.
  logic [15:0] last_addr;
  always_ff @(posedge clk) last_addr <= bus.mem_addr_o;
  assign bus.mem_rdata_i = {~last_addr, last_addr};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic f, input logic r, input logic b,
                     input logic [15:0] ba, input logic em, input logic [15:0] ea,
                     input logic ev, input logic [15:0] eia);
    bus.fetch_en_i    = f;
    bus.instr_ready_i = r;
    bus.branch_i      = b;
    bus.branch_addr_i = ba;
    @(negedge clk);
    chk({tag, ".mem_en"}, 64'(bus.mem_en_o), 64'(em));
    if (em) chk({tag, ".mem_addr"}, 64'(bus.mem_addr_o), 64'(ea));
    chk({tag, ".valid"}, 64'(bus.instr_valid_o), 64'(ev));
    if (ev) begin
      chk({tag, ".iaddr"}, 64'(bus.instr_addr_o), 64'(eia));
      chk({tag, ".idata"}, 64'(bus.instr_rdata_o), 64'({~eia, eia}));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_en_i    = 1'b1;
    bus.instr_ready_i = 1'b1;
    bus.branch_i      = 1'b0;
    bus.branch_addr_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.mem_en", 64'(bus.mem_en_o), 64'd0);
    chk("rst.valid", 64'(bus.instr_valid_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // tag       f  r  b  ba        em ea        ev eia
    cyc("boot0", 1, 1, 0, 16'h0000, 1, 16'h8000, 0, 16'h0000);
    cyc("boot1", 1, 1, 0, 16'h0000, 1, 16'h8004, 0, 16'h0000);
    cyc("boot2", 1, 1, 0, 16'h0000, 1, 16'h8008, 1, 16'h8000);
    cyc("boot3", 1, 1, 0, 16'h0000, 1, 16'h800C, 1, 16'h8004);
    cyc("bp0",   1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h8008);
    cyc("bp1",   1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h8008);
    cyc("bp2",   1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h8008);
    cyc("res0",  1, 1, 0, 16'h0000, 1, 16'h8010, 1, 16'h8008);
    cyc("res1",  1, 1, 0, 16'h0000, 1, 16'h8014, 1, 16'h800C);
    cyc("res2",  1, 1, 0, 16'h0000, 1, 16'h8018, 1, 16'h8010);
    cyc("br0",   1, 1, 1, 16'h0123, 1, 16'h0120, 0, 16'h0000);
    cyc("br1",   1, 1, 0, 16'h0000, 1, 16'h0124, 0, 16'h0000);
    cyc("br2",   1, 1, 0, 16'h0000, 1, 16'h0128, 1, 16'h0120);
    cyc("br3",   1, 1, 0, 16'h0000, 1, 16'h012C, 1, 16'h0124);
    cyc("wrap0", 1, 1, 1, 16'hFFFF, 1, 16'hFFFC, 0, 16'h0000);
    cyc("wrap1", 1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    cyc("wrap2", 1, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'hFFFC);
    cyc("stop0", 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    cyc("stop1", 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    cyc("stop2", 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    cyc("stop3", 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004);
    cyc("stop4", 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    cyc("fill0", 1, 0, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000);
    cyc("fill1", 1, 0, 0, 16'h0000, 1, 16'h000C, 0, 16'h0000);
    cyc("fill2", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008);
    cyc("fill3", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008);

    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", 64'(bus.instr_valid_o), 64'd0);
    chk("mrst.mem_en", 64'(bus.mem_en_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("reboot0", 1, 1, 0, 16'h0000, 1, 16'h8000, 0, 16'h0000);
    cyc("reboot1", 1, 1, 0, 16'h0000, 1, 16'h8004, 0, 16'h0000);
    cyc("reboot2", 1, 1, 0, 16'h0000, 1, 16'h8008, 1, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning byte-address width of the instruction memory port, with the MSB selecting boot ROM.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 2, legal 2..4, meaning instruction FIFO entries.
REQ-004 The block SHALL have parameter BOOT_ADDR, default 16'h8000, meaning first fetch address after reset.
REQ-005 The block SHALL have port clk, input, 1, clock.
REQ-006 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port fetch_en_i, input, 1, permits new memory requests.
REQ-008 The block SHALL have port branch_i, input, 1, redirect request.
REQ-009 The block SHALL have port branch_addr_i, input, ADDR_WIDTH, redirect target; bits [1:0] ignored.
REQ-010 The block SHALL have port mem_en_o, output, 1, memory read request.
REQ-011 The block SHALL have port mem_addr_o, output, ADDR_WIDTH, request byte address, bits [1:0] always 0.
REQ-012 The block SHALL have port mem_rdata_i, input, DATA_WIDTH, read data, valid exactly 1 cycle after mem_en_o.
REQ-013 The block SHALL have port instr_valid_o, output, 1, FIFO head valid.
REQ-014 The block SHALL have port instr_ready_i, input, 1, consumer accepts head.
REQ-015 The block SHALL have port instr_rdata_o, output, DATA_WIDTH, head instruction.
REQ-016 The block SHALL have port instr_addr_o, output, ADDR_WIDTH, head instruction byte address.

Function
REQ-017 The block SHALL implement FSM states IDLE (no requests) and RUN; IDLE->RUN when fetch_en_i=1, RUN->IDLE when fetch_en_i=0, evaluated each cycle.
REQ-018 The block SHALL hold a fetch-address register faddr and a pending flag pend_q marking a request issued in the previous cycle.
REQ-019 The block SHALL assert mem_en_o in a cycle when next state is RUN and (count + pend_q - pop) < DEPTH, where pop = instr_valid_o & instr_ready_i; count and pend_q read as 0 in a branch cycle.
REQ-020 The block SHALL drive mem_addr_o = {branch_addr_i[ADDR_WIDTH-1:2],2'b00} in a branch_i cycle, else faddr.
REQ-021 The block SHALL update faddr to mem_addr_o + 4 on each issued request, wrapping modulo 2^ADDR_WIDTH; on branch_i without a request, faddr SHALL load the aligned branch address.
REQ-022 The block SHALL write mem_rdata_i with its request address into the FIFO tail in the cycle after issue when pend_q=1 and branch_i=0.
REQ-023 The block SHALL present the FIFO head on instr_rdata_o/instr_addr_o; minimum latency from mem_en_o to instr_valid_o SHALL be 2 cycles.
REQ-024 The block SHALL sustain one instruction per cycle when fetch_en_i=1 and instr_ready_i=1 continuously.
REQ-025 The block SHALL, on branch_i=1, empty the FIFO, discard mem_rdata_i of that cycle, force instr_valid_o=0 in that cycle (no pop occurs), and issue the target request in the same cycle if RUN.
REQ-026 The block SHALL handle simultaneous push and pop at full FIFO without data loss or count change.
REQ-027 The block SHALL, when fetch_en_i falls, still capture an outstanding response and retain FIFO contents.
REQ-028 The block SHALL keep instr_rdata_o/instr_addr_o stable while instr_valid_o=1 and instr_ready_i=0.
REQ-029 The block SHALL never overflow the FIFO; count SHALL stay within 0..DEPTH.

Reset
REQ-030 The block SHALL on rst_n=0 set state IDLE, faddr=BOOT_ADDR, pend_q=0, count=0, mem_en_o=0, instr_valid_o=0, FIFO pointers 0.
REQ-031 The block SHALL, on reset asserted mid-operation, drop all pending and buffered data; first request after release SHALL be at BOOT_ADDR.

Verification
REQ-032 Boot: release reset, fetch_en_i=1, ready=1 -> mem_addr_o 0x8000,0x8004,0x8008 on consecutive cycles; instr_valid_o first high 2 cycles after first mem_en_o, one instr/cycle.
REQ-033 Backpressure: ready=0 at DEPTH=2 -> exactly 2 entries buffered, mem_en_o low, head stable; ready=1 -> streaming resumes with no gap or duplicate.
REQ-034 Branch: branch_i=1, branch_addr_i=0x0123 with in-flight response -> mem_addr_o=0x0120 same cycle, stale word discarded, next instr_addr_o=0x0120 then 0x0124.
REQ-035 Wrap: branch to 0xFFFC -> addresses 0xFFFC then 0x0000.
REQ-036 Stop: fetch_en_i=0 one cycle after issue -> outstanding word enters FIFO, no further mem_en_o.
REQ-037 Reset mid-stream with FIFO full -> instr_valid_o=0 immediately, restart at 0x8000.
